// File: rtl/puzzle_setup_debounced_pio_if.sv
// Avalon-MM slave bus for the debounced PIO: one word address space, no waitrequest.
// Writes are accepted on any cycle with write=1; readdata is the word addressed on the previous cycle.
interface puzzle_setup_debounced_pio_if;
   logic [1:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (output address, write, writedata, input readdata, irq);
   modport slave  (input address, write, writedata, output readdata, irq);
endinterface

// File: rtl/puzzle_setup_debounced_pio.sv
// Debounced switch input port: per-bit synchroniser and stability counter,
// edge capture with write-1-to-clear, maskable level interrupt.
module puzzle_setup_debounced_pio #(
   parameter int WIDTH           = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  reset,
   puzzle_setup_debounced_pio_if.slave bus,
   input  logic [WIDTH-1:0]      in_port
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [CW-1:0]    cnt [WIDTH];
   logic [WIDTH-1:0] stab;
   logic [WIDTH-1:0] stab_d;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [1:0]       edgesel;
   logic [WIDTH-1:0] cap_set;
   logic [WIDTH-1:0] cap_clr;
   logic [31:0]      rd_word;
   logic             wr_mask;
   logic             wr_sel;
   logic             wr_cap;

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
         stab <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stab[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               stab[i] <= sync[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign wr_mask = bus.write && (bus.address == 2'd1);
   assign wr_sel  = bus.write && (bus.address == 2'd2);
   assign wr_cap  = bus.write && (bus.address == 2'd3);

   always_comb begin
      cap_set = ((stab & ~stab_d) & {WIDTH{edgesel[0]}})
              | ((~stab & stab_d) & {WIDTH{edgesel[1]}});
      cap_clr = wr_cap ? bus.writedata[WIDTH-1:0] : '0;
   end

   always_comb begin
      rd_word = '0;
      case (bus.address)
         2'd0: rd_word[WIDTH-1:0] = stab;
         2'd1: rd_word[WIDTH-1:0] = irqmask;
         2'd2: rd_word[1:0]       = edgesel;
         default: rd_word[WIDTH-1:0] = edgecap;
      endcase
   end

   // A new capture overrides a simultaneous clear of the same bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         stab_d       <= '0;
         irqmask      <= '0;
         edgesel      <= 2'b01;
         edgecap      <= '0;
         bus.readdata <= '0;
         bus.irq      <= 1'b0;
      end else begin
         stab_d       <= stab;
         if (wr_mask) irqmask <= bus.writedata[WIDTH-1:0];
         if (wr_sel)  edgesel <= bus.writedata[1:0];
         edgecap      <= (edgecap & ~cap_clr) | cap_set;
         bus.readdata <= rd_word;
         bus.irq      <= |(edgecap & irqmask);
      end
   end

   generate
      if (WIDTH < 32) begin : g_unused
         logic unused_wdata;
         assign unused_wdata = &{1'b0, bus.writedata[31:WIDTH]};
      end
   endgenerate

endmodule

// File: doc/puzzle_setup_debounced_pio.md
PUZZLE_SETUP_DEBOUNCED_PIO -- requirements
Module: puzzle_setup_debounced_pio

Interface
- REQ-001 Parameter: WIDTH, default 10, number of input bits; legal range 1..32.
- REQ-002 Parameter: SYNC_STAGES, default 2, synchroniser flops per bit; legal range 2..4.
- REQ-003 Parameter: DEBOUNCE_CYCLES, default 50000, stable-cycle count required to accept a bit change; legal range 1..2^20.
- REQ-004 Port: clk, input, 1, sole clock; all logic SHALL be clocked on its rising edge.
- REQ-005 Port: reset, input, 1, synchronous, active-high reset.
- REQ-006 Port: address, input, 2, Avalon-MM word address.
- REQ-007 Port: write, input, 1, active-high write strobe, one cycle per access.
- REQ-008 Port: writedata, input, 32, write data.
- REQ-009 Port: in_port, input, WIDTH, asynchronous raw switch inputs.
- REQ-010 Port: readdata, output, 32, registered read data.
- REQ-011 Port: irq, output, 1, registered level interrupt, active-high.

Function
- REQ-012 Each in_port bit SHALL pass through a SYNC_STAGES-deep flop chain; sync[i] denotes the last stage.
- REQ-013 Each bit SHALL own a debounce counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits and a stable bit stab[i].
- REQ-014 Per bit, when sync[i]==stab[i], the counter SHALL clear to 0.
- REQ-015 Per bit, when sync[i]!=stab[i] and counter<DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
- REQ-016 Per bit, when sync[i]!=stab[i] and counter==DEBOUNCE_CYCLES-1, stab[i] SHALL take sync[i] and the counter SHALL clear.
- REQ-017 Any glitch shorter than DEBOUNCE_CYCLES cycles at sync[i] SHALL leave stab[i] unchanged.
- REQ-018 Register map: 0 DATA (RO) = stab, zero-extended; 1 IRQMASK (RW, WIDTH bits); 2 EDGESEL (RW, bit0 rise-enable, bit1 fall-enable); 3 EDGECAP (read, write-1-to-clear).
- REQ-019 Writes to address 0 SHALL be ignored; unused writedata bits SHALL be ignored; unused readdata bits SHALL read 0.
- REQ-020 EDGECAP[i] SHALL set on the cycle after stab[i] changes 0->1 when EDGESEL[0]=1, or 1->0 when EDGESEL[1]=1.
- REQ-021 EDGECAP[i] SHALL remain set until cleared by a write of 1 to bit i at address 3.
- REQ-022 If a clear and a new set of the same bit occur in the same cycle, the set SHALL win.
- REQ-023 irq SHALL register |(EDGECAP & IRQMASK) every cycle, giving one cycle of latency after EDGECAP or IRQMASK changes.
- REQ-024 readdata SHALL register the word selected by address every cycle, giving a read latency of 1.
- REQ-025 A read at address 3 in the same cycle as a write SHALL return the pre-write EDGECAP value.
- REQ-026 Total latency from an in_port edge to a stab change SHALL be SYNC_STAGES+DEBOUNCE_CYCLES clocks; EDGECAP SHALL follow 1 clock later and irq 1 clock after that.

Reset
- REQ-027 While reset=1 at a clk edge, the following SHALL clear to 0: synchronisers, counters, stab, IRQMASK, EDGECAP, readdata and irq.
- REQ-028 Reset SHALL set EDGESEL to 2'b01 (rising edge only).
- REQ-029 Reset asserted mid-debounce SHALL abort the count; inputs held high across reset release SHALL produce a rising stab edge SYNC_STAGES+DEBOUNCE_CYCLES clocks after release.

Verification (WIDTH=10, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
- REQ-030 Reset, then read address 0, 1, 2 and 3 -> readdata 0x0, 0x0, 0x1 and 0x0, each valid 1 cycle after the address.
- REQ-031 in_port 0x000->0x005 held -> DATA=0x005 after 6 clocks; EDGECAP=0x005 after 7 clocks; irq stays 0 with IRQMASK=0.
- REQ-032 in_port bit3 pulsed high for 3 clocks -> DATA, EDGECAP and irq remain 0.
- REQ-033 Write IRQMASK=0x004, then stimulus as REQ-031 -> irq=1 at clock 8; write EDGECAP 0x004 -> irq=0 two clocks later, with EDGECAP reading 0x001.
- REQ-034 Write EDGESEL=0x2, then set in_port 0x001->0x000 -> only a fall capture occurs (EDGECAP bit0=1); a write-1-to-clear in the same cycle as a new set leaves the bit set.
- REQ-035 Assert reset at clock 3 of a debounce -> all state returns to 0; with in_port held high, DATA reaches its settled value 6 clocks after reset release.
